// File: rtl/reg_in_skid.sv
// Input capture stage: registers incoming beats into x1 and absorbs in-flight beats in a skid FIFO while stalled.
// Optional sticky overflow flag and drop assertion enabled by defining REG_IN_SKID_OVF_EN.
module reg_in_skid #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         datainv,
    input  logic [DATA_W-1:0]            datain,
    input  logic                         stalled,
    output logic                         datainvx1,
    output logic [DATA_W-1:0]            datainx1,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic                 x1_vld_r;
    logic [DATA_W-1:0]    x1_data_r;
    logic [LVL_W-1:0]     level_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [DATA_W-1:0]    mem_r [DEPTH];

    logic                 pop_s;
    logic                 free_s;
    logic                 fifo_rd_s;
    logic                 bypass_s;
    logic                 wr_req_s;
    logic                 wr_s;
    logic [LVL_W-1:0]     level_nxt_s;

    // Handshake decode: x1 load source, FIFO write acceptance and next occupancy.
    always_comb begin
        pop_s     = x1_vld_r & ~stalled;
        free_s    = ~x1_vld_r | pop_s;
        fifo_rd_s = free_s & (level_r != LVL_ZERO);
        bypass_s  = free_s & (level_r == LVL_ZERO) & datainv;
        wr_req_s  = datainv & ~bypass_s;
        // A full FIFO still accepts when its head moves to x1 on the same edge.
        wr_s      = wr_req_s & ((level_r < LVL_FULL) | fifo_rd_s);
        case ({wr_s, fifo_rd_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // x1 stage, occupancy and FIFO pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x1_vld_r  <= 1'b0;
            x1_data_r <= {DATA_W{1'b0}};
            level_r   <= LVL_ZERO;
            rd_ptr_r  <= {PTR_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
        end else begin
            if (fifo_rd_s) begin
                x1_vld_r  <= 1'b1;
                x1_data_r <= mem_r[rd_ptr_r];
            end else if (bypass_s) begin
                x1_vld_r  <= 1'b1;
                x1_data_r <= datain;
            end else if (free_s) begin
                x1_vld_r  <= 1'b0;
            end else begin
                x1_vld_r  <= x1_vld_r;
            end
            level_r <= level_nxt_s;
            if (fifo_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
        end
    end

    // Skid storage; contents are only observed while level is non-zero, so no reset is needed.
    always_ff @(posedge clock) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= datain;
        end
    end

    assign datainvx1 = x1_vld_r;
    assign datainx1  = x1_data_r;
    assign level     = level_r;

`ifdef REG_IN_SKID_OVF_EN
    logic drop_s;
    logic ovf_r;

    assign drop_s = wr_req_s & ~wr_s;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;

    reg_in_skid_chk u_chk (
        .clock (clock),
        .reset (reset),
        .drop  (drop_s)
    );
`else
    assign ovf = 1'b0;
`endif

endmodule

`ifdef REG_IN_SKID_OVF_EN
// Flags any dropped beat in simulation.
module reg_in_skid_chk (
    input logic clock,
    input logic reset,
    input logic drop
);
    a_no_drop: assert property (@(posedge clock) disable iff (reset) !drop)
        else $error("reg_in_skid: beat dropped, skid FIFO overflow");
endmodule
`endif

// File: tb/tb_reg_in_skid.sv
// Bench for reg_in_skid: vector table for passthrough/skid plus scoreboard-checked reset, overflow, full and wrap sequences.
module tb_reg_in_skid;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef REG_IN_SKID_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              datainv = 1'b0;
    logic [DATA_W-1:0] datain = 8'h00;
    logic              stalled = 1'b0;
    logic              datainvx1;
    logic [DATA_W-1:0] datainx1;
    logic [2:0]        level;
    logic              ovf;

    reg_in_skid #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .datainv   (datainv),
        .datain    (datain),
        .stalled   (stalled),
        .datainvx1 (datainvx1),
        .datainx1  (datainx1),
        .level     (level),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
    } vec_t;

    vec_t       tbl [15];
    logic [7:0] q [$];
    logic [7:0] last_x1 = 8'h00;
    int         drops = 0;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_v"}, {31'd0, datainvx1}, 32'd0);
        check({nm, "_d"}, {24'd0, datainx1}, 32'd0);
        check({nm, "_lvl"}, {29'd0, level}, 32'd0);
        check({nm, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    // One clock: drive at negedge, update the scoreboard at the edge, compare just after it.
    task automatic cycle(input logic v, input logic [7:0] d, input logic st);
        int   qs;
        logic pop;
        logic acc;
        @(negedge clock);
        datainv = v;
        datain  = d;
        stalled = st;
        qs  = q.size();
        pop = (qs > 0) && !st;
        acc = v && ((qs - (pop ? 1 : 0)) < DEPTH + 1);
        @(posedge clock);
        #1;
        if (pop) void'(q.pop_front());
        if (v) begin
            if (acc) q.push_back(d);
            else drops++;
        end
        if (q.size() > 0) last_x1 = q[0];
        check("x1_valid", {31'd0, datainvx1}, {31'd0, (q.size() > 0)});
        check("x1_data", {24'd0, datainx1}, {24'd0, last_x1});
        check("level", {29'd0, level}, (q.size() > 0) ? q.size() - 1 : 0);
        check("ovf", {31'd0, ovf}, {31'd0, OVF_EN && (drops > 0)});
    endtask

    task automatic apply_reset();
        @(negedge clock);
        datainv = 1'b0;
        stalled = 1'b0;
        reset   = 1'b1;
        #1;
        check_reset_vals("rst");
        q.delete();
        last_x1 = 8'h00;
        drops   = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic prev_st;
        logic st;
        int   sent;

        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd0};
        tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 3'd0};
        tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 3'd0};
        tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h04, 3'd0};
        tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 3'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 3'd0};
        tbl[6]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd0};
        tbl[7]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 8'hA0, 3'd1};
        tbl[8]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hA0, 3'd2};
        tbl[9]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA0, 3'd3};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA0, 3'd3};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 3'd2};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA2, 3'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 3'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA3, 3'd0};

        // Power-up reset state.
        #12;
        check_reset_vals("por");
        @(negedge clock);
        reset = 1'b0;

        // Reset asserted mid-cycle while a beat is in flight.
        cycle(1'b1, 8'h11, 1'b0);
        check("pre_rst_x1", {24'd0, datainx1}, 32'h11);
        #3;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        q.delete();
        last_x1 = 8'h00;
        drops   = 0;
        @(negedge clock);
        datainv = 1'b0;
        reset   = 1'b0;
        cycle(1'b1, 8'h22, 1'b0);
        check("post_rst_x1", {24'd0, datainx1}, 32'h22);
        cycle(1'b0, 8'h00, 1'b0);

        // Passthrough and skid vectors.
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].st);
            check("tbl_v", {31'd0, datainvx1}, {31'd0, tbl[i].ev});
            check("tbl_d", {24'd0, datainx1}, {24'd0, tbl[i].ed});
            check("tbl_lvl", {29'd0, level}, {29'd0, tbl[i].el});
        end

        // Overflow: six beats into a stalled core, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h10 + 8'(i), 1'b1);
        end
        check("ovf_x1", {24'd0, datainx1}, 32'h10);
        check("ovf_lvl", {29'd0, level}, 32'd4);
        check("ovf_flag", {31'd0, ovf}, {31'd0, OVF_EN});
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
        end
        check("ovf_sticky", {31'd0, ovf}, {31'd0, OVF_EN});
        apply_reset();

        // Full FIFO with simultaneous write and head move.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h20 + 8'(i), 1'b1);
        end
        check("full_lvl", {29'd0, level}, 32'd4);
        cycle(1'b1, 8'h55, 1'b0);
        check("full_push_pop_lvl", {29'd0, level}, 32'd4);
        check("full_push_pop_x1", {24'd0, datainx1}, 32'h21);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
        end
        check("full_last", {24'd0, datainx1}, 32'h55);
        check("full_nodrop", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
        end

        // Wrap-around: many beats with random single-cycle stalls.
        prev_st = 1'b0;
        sent    = 0;
        for (int c = 0; c < 300 && sent < 40; c++) begin
            st = prev_st ? 1'b0 : ($urandom_range(0, 2) == 0);
            if (q.size() < DEPTH) begin
                cycle(1'b1, 8'h80 + 8'(sent), st);
                sent++;
            end else begin
                cycle(1'b0, 8'h00, st);
            end
            prev_st = st;
        end
        check("wrap_sent", sent, 32'd40);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
        end
        check("wrap_last", {24'd0, datainx1}, 32'h80 + 32'd39);
        check("wrap_ovf", {31'd0, ovf}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
